bcd_ex3_seq_ctrl: RTL and testbench
===================================

Name: bcd_ex3_seq_ctrl

Overview:
- Serial controller that converts a multi-digit packed-BCD word to Excess-3 one digit per cycle through a single shared 4-bit digit converter.
- Sits between a BCD producer and an Excess-3 consumer, with valid/ready handshakes on both sides.
- Flags any non-BCD input digit (greater than 9) with a sticky error bit for the word.

Parameters:
- DIGITS, 4, number of BCD digits per word. Legal range 1..16.
- DW, 4*DIGITS, packed word width. Derived; must not be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word on in_bcd.
- in_ready  out  1  controller can accept a word.
- in_bcd  in  DW  packed BCD; digit 0 is in_bcd[3:0].
- out_valid  out  1  converted word available.
- out_ready  in  1  consumer accepts the word.
- out_ex3  out  DW  packed Excess-3 result; digit i is in bits [4i+3:4i].
- out_err  out  1  at least one input digit was greater than 9.
- busy  out  1  conversion in progress (state CONV).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE, so in_ready=1 once rst deasserts.
  - out_valid=0, out_ex3=0, out_err=0, busy=0.
  - Digit index = 0; captured word register = 0.
- rst has priority over every other event.
  - Reset mid-CONV or in DONE aborts the word; the result is discarded and not presented.
  - Handshakes sampled while rst=1 are ignored.
- FSM states: IDLE, CONV, DONE.
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==CONV). All decoded from registered state.
- IDLE:
  - On in_valid & in_ready: capture in_bcd, clear the result register, clear out_err, set index=0, go to CONV.
  - Otherwise hold.
- CONV, one digit per cycle, LSB digit first:
  - Shared converter input = captured digit[index].
  - result nibble[index] <= digit + 3, taken mod 16.
  - out_err <= out_err | (digit > 9).
  - index increments each cycle. When index==DIGITS-1, index resets to 0 and state goes to DONE.
- Latency: a word accepted at edge T has out_valid=1 in the cycle following edge T+DIGITS.
- DONE:
  - out_ex3 and out_err are held stable while out_valid & !out_ready (backpressure of any length).
  - On out_ready: go to IDLE. Result registers keep their values until the next accept.
- Throughput: at most one word per DIGITS+2 cycles. There is no accept in the same cycle as out handshake completion; in_ready rises the cycle after.
- in_bcd changes while state is not IDLE have no effect, because the word was captured at accept.
- Invalid digits (A–F) still produce digit+3 mod 16 (A->D, D->0, F->2) and set out_err. Conversion is not aborted.
- DIGITS=1: CONV lasts exactly one cycle.
- The index counter width is clog2(DIGITS), minimum 1 bit. It never exceeds DIGITS-1.

Decomposition:
- Shared package bcd_pkg:
  - Constants EX3_OFFSET=4'd3 and BCD_MAX=4'd9.
  - Typedef bcd_digit_t (4-bit).
  - FSM state enum ctrl_state_t {IDLE, CONV, DONE}.
- One sub-module, ex3_digit: combinational, input d[3:0], outputs e[3:0]=d+3 and err=(d>9). Instantiated once and time-shared by the controller.

Test Plan:
- Basic: DIGITS=4, in_bcd=16'h5029 accepted, out_ready=1 -> after 4 CONV cycles out_ex3=16'h835C, out_err=0. out_valid is high for exactly 1 cycle, then in_ready=1.
- Max digits: in_bcd=16'h9999 -> out_ex3=16'hCCCC, out_err=0. in_bcd=16'h0000 -> out_ex3=16'h3333.
- Invalid digit: in_bcd=16'h00A3 -> out_ex3=16'h33D6, out_err=1. The next word 16'h0001 -> 16'h3334 with out_err=0, showing the error is cleared on accept.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_ex3 and out_valid stable and in_ready=0 throughout. Raising out_ready gives one handshake, then IDLE.
- Reset mid-op: assert rst for 1 cycle at the 2nd CONV cycle of 16'h1234 -> next cycle state IDLE, out_valid=0, out_ex3=0, out_err=0, in_ready=1. No stale result ever appears.
- Back-to-back: in_valid held high with 16'h1234 then 16'h5678 -> outputs 16'h4567 then 16'h89AB, accepts spaced exactly DIGITS+2 cycles apart. Changing in_bcd during CONV does not alter the result.

Source files
------------

// File: rtl/bcd_ex3_seq_ctrl_pkg.sv
// Shared types and constants for the serial BCD to Excess-3 controller.
package bcd_pkg;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/bcd_ex3_seq_ctrl_if.sv
// Producer and consumer handshakes of the BCD to Excess-3 controller.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; valid holds its data stable until then.
interface bcd_ex3_seq_ctrl_if #(
  parameter int DIGITS = 4
) ();
  localparam int DW = 4 * DIGITS;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_bcd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_ex3;
  logic          out_err;
  logic          busy;

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_ex3, out_err, busy
  );

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_ex3, out_err, busy
  );
endinterface

// File: rtl/bcd_ex3_seq_ctrl_ex3_digit.sv
// Single-digit BCD to Excess-3 converter; out-of-range digits wrap mod 16.
module ex3_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t e,
  output logic       err
);
  assign e   = d + EX3_OFFSET;
  assign err = (d > BCD_MAX);
endmodule

// File: rtl/bcd_ex3_seq_ctrl.sv
// Serial packed-BCD to Excess-3 controller: one digit per cycle through a
// single shared ex3_digit, LSB digit first, with a sticky per-word error.
module bcd_ex3_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_ex3_seq_ctrl_if.slave   bus,
  output ctrl_state_t         dbg_state
);
  localparam int DW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  ctrl_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] word_q, word_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;

  bcd_digit_t cur_digit;
  bcd_digit_t cur_e;
  logic       cur_err;

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_digit = word_q[4*i +: 4];
    end
  end

  ex3_digit u_ex3_digit (
    .d   (cur_digit),
    .e   (cur_e),
    .err (cur_err)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // in_ready is exactly state==IDLE, so in_valid alone completes the accept
        if (bus.in_valid) begin
          word_d  = bus.in_bcd;
          res_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) res_d[4*i +: 4] = cur_e;
        end
        err_d = err_q | cur_err;
        if (idx_q == IW'(DIGITS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CONV);
  assign bus.out_ex3   = res_q;
  assign bus.out_err   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Bench for bcd_ex3_seq_ctrl: directed and random words, queue scoreboard
// fed at input accept and drained by an output monitor.
module tb_bcd_ex3_seq_ctrl;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;
  localparam int CW     = DW + 1;
  typedef logic [CW-1:0] cw_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ctrl_state_t dbg_state;

  bcd_ex3_seq_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_ex3_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int  cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int  n_tests   = 0;
  int  n_fail    = 0;
  int  out_count = 0;
  int  last_acc  = -1;
  int  prev_acc  = -1;
  logic rand_bp  = 1'b0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string name, input cw_t act, input cw_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each digit d becomes (d+3) mod 16; any d>9 flags the word.
  function automatic cw_t model(input logic [DW-1:0] w);
    int            d;
    logic [DW-1:0] r;
    logic          err;
    r   = '0;
    err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((w >> (4 * i)) & DW'(15));
      r = r | (DW'((d + 3) % 16) << (4 * i));
      if (d > 9) err = 1'b1;
    end
    return {err, r};
  endfunction

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      check("one_of_ready_busy_valid",
            cw_t'(int'(bus.in_ready) + int'(bus.busy) + int'(bus.out_valid)), cw_t'(1));
      if (prev_hs)
        check("idle_after_out_hs", cw_t'({bus.out_valid, bus.in_ready}), cw_t'(2'b01));
      if (bus.out_valid && !prev_valid)
        check("latency", cw_t'(cyc - last_acc), cw_t'(DIGITS));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", {bus.out_err, bus.out_ex3});
        end else begin
          check("result", {bus.out_err, bus.out_ex3}, exp_q.pop_front());
        end
        out_count++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_bcd));
        prev_acc = last_acc;
        last_acc = cyc + 1;
      end
      prev_hs    = bus.out_valid && bus.out_ready;
      prev_valid = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] w, input bit hold_valid);
    int budget;
    bit acc;
    budget = 0;
    acc    = 1'b0;
    bus.in_bcd   = w;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_ready && !rst;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 100);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of %h", w);
    end
    if (!hold_valid) bus.in_valid = 1'b0;
    bus.in_bcd = DW'($urandom);
  endtask

  task automatic wait_out(input int n);
    int b;
    b = 0;
    while (out_count < n && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (out_count < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_timeout: got %0d outputs expected %0d", out_count, n);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] dir_in [5]  = '{16'h5029, 16'h9999, 16'h0000, 16'h00A3, 16'h0001};
  cw_t           dir_exp[5]  = '{{1'b0, 16'h835C}, {1'b0, 16'hCCCC}, {1'b0, 16'h3333},
                                 {1'b1, 16'h33D6}, {1'b0, 16'h3334}};
  int            n_out;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;
    n_out = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",  cw_t'(bus.in_ready),  cw_t'(1));
    check("rst_out_valid", cw_t'(bus.out_valid), cw_t'(0));
    check("rst_busy",      cw_t'(bus.busy),      cw_t'(0));
    check("rst_out",       {bus.out_err, bus.out_ex3}, cw_t'(0));
    check("rst_state",     cw_t'(dbg_state),     cw_t'(IDLE));

    // directed words; results are held in the registers after the handshake
    for (int i = 0; i < 5; i++) begin
      send(dir_in[i], 1'b0);
      n_out++;
      wait_out(n_out);
      check("directed_held", {bus.out_err, bus.out_ex3}, dir_exp[i]);
    end

    // backpressure for 5 cycles
    bus.out_ready = 1'b0;
    send(16'h4821, 1'b0);
    for (int b = 0; b < 50 && !bus.out_valid; b++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid_seen", cw_t'(bus.out_valid), cw_t'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid",    cw_t'(bus.out_valid), cw_t'(1));
      check("bp_in_ready", cw_t'(bus.in_ready),  cw_t'(0));
      check("bp_data",     {bus.out_err, bus.out_ex3}, {1'b0, 16'h7B54});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    n_out++;
    wait_out(n_out);

    // reset during the second CONV cycle discards the word
    send(16'h1234, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_state",     cw_t'(dbg_state),     cw_t'(IDLE));
    check("mid_rst_in_ready",  cw_t'(bus.in_ready),  cw_t'(1));
    check("mid_rst_out_valid", cw_t'(bus.out_valid), cw_t'(0));
    check("mid_rst_out",       {bus.out_err, bus.out_ex3}, cw_t'(0));
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_output", cw_t'(out_count), cw_t'(n_out));

    // back-to-back with in_valid held; in_bcd changes during CONV
    send(16'h1234, 1'b1);
    send(16'h5678, 1'b0);
    check("b2b_spacing", cw_t'(last_acc - prev_acc), cw_t'(DIGITS + 2));
    n_out += 2;
    wait_out(n_out);
    check("b2b_last_held", {bus.out_err, bus.out_ex3}, {1'b0, 16'h89AB});

    // random words with random consumer backpressure
    rand_bp = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [DW-1:0] w;
      w = '0;
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 3) == 0) w[4*d +: 4] = 4'($urandom_range(0, 15));
        else                           w[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      send(w, 1'b0);
      n_out++;
      wait_out(n_out);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    check("queue_drained", cw_t'(exp_q.size()), cw_t'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
